// File: rtl/param_theta_encoder_pkg.sv
// Shared definitions for the parametrised theta slice encoder.
//   SLICE_W / LANES : slice width (5x5 bits) and lane count per row.
//   ST_*            : controller state encodings.
//   bit_idx         : position of lane (x,y) within a slice.
//   theta_d         : 5-bit theta D vector from the current and previous
//                     slice column parities.
package encoder_pkg;

  localparam int SLICE_W = 25;
  localparam int LANES   = 5;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_PARITY = 3'd2;
  localparam state_t ST_APPLY  = 3'd3;
  localparam state_t ST_OUTPUT = 3'd4;

  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  // D[x] = C[z][x-1] ^ C[z-1][x+1], indices modulo 5.
  function automatic logic [LANES-1:0] theta_d(input logic [LANES-1:0] c_cur,
                                               input logic [LANES-1:0] c_prev);
    logic [LANES-1:0] d;
    for (int x = 0; x < LANES; x++) begin
      d[x] = c_cur[(x + 4) % LANES] ^ c_prev[(x + 1) % LANES];
    end
    return d;
  endfunction

endpackage

// File: rtl/param_theta_encoder_if.sv
// Handshake bundle between the slice loader, the encoder and the downstream
// permutation stages.
//   start/mode/rounds/in      : job request and input slice (master -> slave)
//   ready/putInput/outReady/out : status and output slice (slave -> master)
interface param_theta_encoder_if
  import encoder_pkg::*;
#(
  parameter int MAX_ROUNDS = 24,
  parameter int ROUND_W    = $clog2(MAX_ROUNDS + 1)
);
  logic               start;
  logic               mode;
  logic [ROUND_W-1:0] rounds;
  logic [SLICE_W-1:0] in;
  logic               ready;
  logic               putInput;
  logic               outReady;
  logic [SLICE_W-1:0] out;

  modport master (output start, mode, rounds, in,
                  input  ready, putInput, outReady, out);
  modport slave  (input  start, mode, rounds, in,
                  output ready, putInput, outReady, out);
endinterface

// File: rtl/param_theta_encoder_slice_parity.sv
// Column parity of one 25-bit slice: par[x] = XOR over y of slice[5y+x].
//   slice : input slice
//   par   : 5-bit column parity
module slice_parity
  import encoder_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  output logic [LANES-1:0]   par
);

  always_comb begin
    par = '0;
    for (int x = 0; x < LANES; x++) begin
      for (int y = 0; y < LANES; y++) begin
        par[x] = par[x] ^ slice[bit_idx(x, y)];
      end
    end
  end

endmodule

// File: rtl/param_theta_encoder.sv
// Parametrised theta encoder: loads DEPTH serial slices, applies 0..MAX_ROUNDS
// theta rounds in place (one PARITY pass then one APPLY pass per round), and
// streams the state back out slice by slice.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of the start/ready/putInput/outReady handshake
module param_theta_encoder
  import encoder_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int MAX_ROUNDS = 24,
  parameter int ROUND_W    = $clog2(MAX_ROUNDS + 1)
) (
  input logic                  clk,
  input logic                  rst,
  param_theta_encoder_if.slave bus
);

  localparam int                 Z_W    = $clog2(DEPTH);
  localparam logic [Z_W-1:0]     Z_LAST = Z_W'(DEPTH - 1);
  localparam logic [ROUND_W-1:0] R_MAX  = ROUND_W'(MAX_ROUNDS);

  // Bypass and a zero round count both collapse to R=0; oversize counts clamp.
  function automatic logic [ROUND_W-1:0] eff_rounds(input logic m,
                                                    input logic [ROUND_W-1:0] r);
    if (!m) return '0;
    return (r > R_MAX) ? R_MAX : r;
  endfunction

  state_t             state_q, state_d;
  logic [Z_W-1:0]     z_q, z_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] rtot_q, rtot_d;
  logic               ready_q, ready_d;
  logic               put_q, put_d;
  logic               ordy_q, ordy_d;
  logic [SLICE_W-1:0] out_q, out_d;

  logic [SLICE_W-1:0] mem_q [DEPTH];
  logic [LANES-1:0]   par_q [DEPTH];
  logic               mem_we, par_we;
  logic [SLICE_W-1:0] mem_wd;

  logic [Z_W-1:0]     z_prev;
  logic [SLICE_W-1:0] cur_slice;
  logic [LANES-1:0]   cur_par;
  logic [LANES-1:0]   d_vec;

  assign cur_slice = mem_q[z_q];
  assign z_prev    = (z_q == '0) ? Z_LAST : z_q - 1'b1;
  assign d_vec     = theta_d(par_q[z_q], par_q[z_prev]);

  slice_parity u_parity (
    .slice (cur_slice),
    .par   (cur_par)
  );

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    round_d = round_q;
    rtot_d  = rtot_q;
    mem_we  = 1'b0;
    mem_wd  = bus.in;
    par_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          z_d     = '0;
          round_d = '0;
          rtot_d  = eff_rounds(bus.mode, bus.rounds);
        end
      end
      ST_LOAD: begin
        mem_we = 1'b1;
        if (z_q == Z_LAST) begin
          z_d     = '0;
          state_d = (rtot_q == '0) ? ST_OUTPUT : ST_PARITY;
        end else begin
          z_d = z_q + 1'b1;
        end
      end
      ST_PARITY: begin
        par_we = 1'b1;
        if (z_q == Z_LAST) begin
          z_d     = '0;
          state_d = ST_APPLY;
        end else begin
          z_d = z_q + 1'b1;
        end
      end
      ST_APPLY: begin
        mem_we = 1'b1;
        // D[x] hits every row y of the slice, so replicate it five times.
        mem_wd = cur_slice ^ {LANES{d_vec}};
        if (z_q == Z_LAST) begin
          z_d     = '0;
          round_d = round_q + 1'b1;
          state_d = (round_d < rtot_q) ? ST_PARITY : ST_OUTPUT;
        end else begin
          z_d = z_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (z_q == Z_LAST) begin
          z_d     = '0;
          state_d = ST_IDLE;
        end else begin
          z_d = z_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state, so each one lines up with
    // the cycle its state is occupied; out preloads the slice to be shown.
    ready_d = (state_d == ST_IDLE);
    put_d   = (state_d == ST_LOAD);
    ordy_d  = (state_d == ST_OUTPUT);
    out_d   = ordy_d ? mem_q[z_d] : '0;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      z_q     <= '0;
      round_q <= '0;
      rtot_q  <= '0;
      ready_q <= 1'b1;
      put_q   <= 1'b0;
      ordy_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      round_q <= round_d;
      rtot_q  <= rtot_d;
      ready_q <= ready_d;
      put_q   <= put_d;
      ordy_q  <= ordy_d;
      out_q   <= out_d;
    end
  end

  // Slice and parity storage (contents not reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[z_q] <= mem_wd;
    if (par_we) par_q[z_q] <= cur_par;
  end

  assign bus.ready    = ready_q;
  assign bus.putInput = put_q;
  assign bus.outReady = ordy_q;
  assign bus.out      = out_q;

endmodule

// File: tb/tb_param_theta_encoder.sv
module tb_param_theta_encoder;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_theta_encoder_if #(.MAX_ROUNDS(24)) b4 ();
  param_theta_encoder_if #(.MAX_ROUNDS(24)) b64 ();

  param_theta_encoder #(.DEPTH(4), .MAX_ROUNDS(24)) dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave));
  param_theta_encoder #(.DEPTH(64), .MAX_ROUNDS(24)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.slave));

  logic        start_r = 1'b0;
  logic        mode_r  = 1'b0;
  logic [4:0]  rounds_r = '0;
  logic [24:0] in_r    = '0;
  logic        sel64   = 1'b0;

  assign b4.start   = start_r & ~sel64;
  assign b64.start  = start_r & sel64;
  assign b4.mode    = mode_r;
  assign b64.mode   = mode_r;
  assign b4.rounds  = rounds_r;
  assign b64.rounds = rounds_r;
  assign b4.in      = in_r;
  assign b64.in     = in_r;

  logic        o_ready, o_put, o_ordy;
  logic [24:0] o_out;
  assign o_ready = sel64 ? b64.ready    : b4.ready;
  assign o_put   = sel64 ? b64.putInput : b4.putInput;
  assign o_ordy  = sel64 ? b64.outReady : b4.outReady;
  assign o_out   = sel64 ? b64.out      : b4.out;

  int checks = 0;
  int errors = 0;

  logic [24:0] stim  [64];
  logic [24:0] exp_s [64];
  logic [24:0] got   [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: theta over a 5x5xd state, computed straight from its definition.
  task automatic ref_theta(input int d, input int r);
    logic [4:0] c [64];
    for (int z = 0; z < d; z++) exp_s[z] = stim[z];
    for (int n = 0; n < r; n++) begin
      for (int z = 0; z < d; z++)
        for (int x = 0; x < 5; x++) begin
          c[z][x] = 1'b0;
          for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ exp_s[z][5*y+x];
        end
      for (int z = 0; z < d; z++)
        for (int y = 0; y < 5; y++)
          for (int x = 0; x < 5; x++)
            exp_s[z][5*y+x] = exp_s[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+d-1)%d][(x+1)%5];
    end
  endtask

  function automatic int eff_r(input bit m, input int r);
    if (!m) return 0;
    return (r > 24) ? 24 : r;
  endfunction

  // Runs one complete job on the selected instance and checks everything.
  task automatic run_job(input int d, input bit m, input int r, input bit pulse_in_load,
                         input string tag);
    int cyc, nload, nout, first_put, last_load, first_out, exp_lat;
    bit done;
    sel64 = (d == 64);
    exp_lat = 2 * d * eff_r(m, r) + 1;
    cyc = 0;
    while (!o_ready && cyc < 500) begin @(negedge clk); cyc++; end
    chk({tag, " ready_before"}, 32'(o_ready), 32'd1);
    mode_r = m; rounds_r = 5'(r); start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    chk({tag, " ready_drop"}, 32'(o_ready), 32'd0);
    nload = 0; nout = 0; first_put = -1; last_load = -1; first_out = -1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 2000) begin
      start_r = 1'b0;
      if (o_put) begin
        if (first_put < 0) first_put = cyc;
        if (nload < 64) in_r = stim[nload];
        nload++;
        last_load = cyc;
        if (pulse_in_load && nload == 2) start_r = 1'b1;
      end
      if (o_ordy) begin
        if (first_out < 0) first_out = cyc;
        if (nout < 64) got[nout] = o_out;
        nout++;
      end else if (nout > 0) begin
        done = 1'b1;
      end
      if (!done) begin @(negedge clk); cyc++; end
    end
    start_r = 1'b0;
    chk({tag, " completed"}, 32'(done), 32'd1);
    chk({tag, " put_latency"}, 32'(first_put), 32'd0);
    chk({tag, " put_cycles"}, 32'(nload), 32'(d));
    chk({tag, " out_cycles"}, 32'(nout), 32'(d));
    chk({tag, " out_latency"}, 32'(first_out - last_load), 32'(exp_lat));
    for (int k = 0; k < d; k++) chk($sformatf("%s out[%0d]", tag, k), 32'(got[k]), 32'(exp_s[k]));
    chk({tag, " ready_after"}, 32'(o_ready), 32'd1);
    chk({tag, " out_zero_after"}, 32'(o_out), 32'd0);
  endtask

  initial begin
    int m, r, ordy_seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready4", 32'(b4.ready), 32'd1);
    chk("rst put4", 32'(b4.putInput), 32'd0);
    chk("rst ordy4", 32'(b4.outReady), 32'd0);
    chk("rst out4", 32'(b4.out), 32'd0);
    chk("rst ready64", 32'(b64.ready), 32'd1);
    chk("rst ordy64", 32'(b64.outReady), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single bit in slice 0, one round
    stim[0] = 25'h1; stim[1] = '0; stim[2] = '0; stim[3] = '0;
    exp_s[0] = 25'h0210843; exp_s[1] = 25'h1084210; exp_s[2] = '0; exp_s[3] = '0;
    run_job(4, 1'b1, 1, 1'b0, "t1");

    // Single bit in last slice: effect wraps to slice 0
    stim[0] = '0; stim[1] = '0; stim[2] = '0; stim[3] = 25'h1;
    exp_s[0] = 25'h1084210; exp_s[1] = '0; exp_s[2] = '0; exp_s[3] = 25'h0210843;
    run_job(4, 1'b1, 1, 1'b0, "t2_wrap");

    // All ones: parities cancel
    for (int k = 0; k < 4; k++) begin stim[k] = 25'h1FFFFFF; exp_s[k] = 25'h1FFFFFF; end
    run_job(4, 1'b1, 3, 1'b0, "t3_ones");

    // Bypass on the deep instance, by mode and by zero rounds
    for (int k = 0; k < 64; k++) begin stim[k] = 25'($urandom); exp_s[k] = stim[k]; end
    run_job(64, 1'b0, 5, 1'b0, "t4_bypass");
    for (int k = 0; k < 64; k++) begin stim[k] = 25'($urandom); exp_s[k] = stim[k]; end
    run_job(64, 1'b1, 0, 1'b0, "t4_r0");

    // Two rounds against the model
    stim[0] = 25'h1; stim[1] = '0; stim[2] = '0; stim[3] = '0;
    ref_theta(4, 2);
    run_job(4, 1'b1, 2, 1'b0, "t5_r2");

    // Saturating round count
    for (int k = 0; k < 4; k++) stim[k] = 25'($urandom);
    ref_theta(4, 24);
    run_job(4, 1'b1, 31, 1'b0, "t5_sat");

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      m = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 31));
      for (int k = 0; k < 4; k++) stim[k] = 25'($urandom);
      ref_theta(4, eff_r(m[0], r));
      run_job(4, m[0], r, 1'b0, $sformatf("rnd%0d", j));
    end

    // Abort a two-round job during APPLY
    sel64 = 1'b0;
    stim[0] = 25'h1; stim[1] = '0; stim[2] = '0; stim[3] = '0;
    mode_r = 1'b1; rounds_r = 5'd2; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) in_r = stim[k];
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("abort ready", 32'(b4.ready), 32'd1);
    chk("abort ordy", 32'(b4.outReady), 32'd0);
    chk("abort put", 32'(b4.putInput), 32'd0);
    chk("abort out", 32'(b4.out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ordy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b4.outReady) ordy_seen++;
    end
    chk("abort no_partial_out", 32'(ordy_seen), 32'd0);

    // First job replayed after the abort, with a stray start during LOAD
    exp_s[0] = 25'h0210843; exp_s[1] = 25'h1084210; exp_s[2] = '0; exp_s[3] = '0;
    run_job(4, 1'b1, 1, 1'b1, "t6_after_abort");
    repeat (3) @(negedge clk);
    chk("t6 no_restart", 32'(b4.ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
